control_sched: RTL
==================

CONTROL_SCHED -- requirements
Module: control_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-002 SHALL have parameter DRAIN_CYCLES, default T_D, issue-stall cycles after a drain instruction (>=1).
REQ-003 SHALL have parameter FETCH_LAT, default 1, issue-to-ctrl_signals.fetch delay in cycles (>=1).
REQ-004 SHALL have parameter COMMIT_LAT, default T_D+1, issue-to-ctrl_signals.commit delay in cycles (>=FETCH_LAT).
REQ-005 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port inst_i  input  instruction_t  incoming instruction.
REQ-008 SHALL have port inst_valid_i  input  1  inst_i valid.
REQ-009 SHALL have port inst_ready_o  output  1  buffer can accept; transfer on valid&&ready.
REQ-010 SHALL have port flush_i  input  1  synchronous abort of buffered and in-flight work.
REQ-011 SHALL have port ctrl_signals  output  ctrl_signals_t  delayed fetch and commit control.
REQ-012 SHALL have port fifo_count_o  output  $clog2(FIFO_DEPTH)+1  buffered instruction count.
REQ-013 SHALL have port busy_o  output  1  high while any instruction is buffered, draining or in flight.

Function
REQ-014 SHALL push inst_i into a FIFO on inst_valid_i && inst_ready_o; inst_ready_o = !full, with no dependence on same-cycle pop (no pass-through when full).
REQ-015 SHALL feed the FIFO head to the existing decoder combinationally; an entry is issued in a cycle when FIFO non-empty, state ISSUE and !flush_i, and popped that cycle.
REQ-016 SHALL use states ISSUE and DRAIN; ISSUE->DRAIN when the issued entry decodes fetch.drain=1, loading drain counter with DRAIN_CYCLES.
REQ-017 SHALL in DRAIN issue nothing, decrement counter each cycle, return to ISSUE in the cycle after counter reaches 1 (exactly DRAIN_CYCLES stall cycles).
REQ-018 SHALL, when no entry is issued, present all-zero fetch and commit valids to the delay pipelines.
REQ-019 SHALL delay issued fetch signals by FETCH_LAT and commit signals by COMMIT_LAT flops, valids and payload together.
REQ-020 SHALL let an instruction accepted in cycle N issue no earlier than N+1; fetch valid appears at issue+FETCH_LAT.
REQ-021 SHALL allow simultaneous push and pop when not full; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL on flush_i: empty FIFO, clear drain counter, go to ISSUE, zero every valid in both pipelines next cycle; a same-cycle push is dropped.
REQ-023 SHALL drive busy_o = (count!=0) || (state==DRAIN) || any pipeline stage valid.

Reset
REQ-024 SHALL on rst_i asserted asynchronously clear FIFO pointers and count, drain counter, state to ISSUE, all pipeline stages to '0.
REQ-025 SHALL hold outputs during reset at: inst_ready_o=1 (deasserted only if reset released mid-cycle, never 0 while reset), ctrl_signals='0, fifo_count_o=0, busy_o=0.
REQ-026 SHALL discard all buffered and in-flight instructions on reset mid-operation, with no partial outputs after release.

Structure
REQ-027 SHALL take instruction_t, ctrl_signals_t and T_D from common_pkg; no new package types required.
REQ-028 SHALL reuse the existing decoder module unchanged.
REQ-029 SHALL implement the buffer as one new sub-module inst_fifo (parametrised width/depth, push/pop/flush, full/empty/count).
REQ-030 SHALL build delay pipelines as parametrised flop chains; FETCH_LAT and COMMIT_LAT independent.

Verification (FIFO_DEPTH=4, DRAIN_CYCLES=3, FETCH_LAT=1, COMMIT_LAT=4)
REQ-031 SHALL cover: single non-drain instr accepted cycle 0 -> fetch.valid=1 cycle 2 only, commit.valid=1 cycle 5 only, busy_o low from cycle 6.
REQ-032 SHALL cover: drain instr accepted cycle 0, normal instr cycle 1 -> drain issued cycle 1, normal issued cycle 5, fetch valids cycles 2 and 6.
REQ-033 SHALL cover: 5 back-to-back pushes, no issue possible (drain ahead) -> inst_ready_o low after 4, fifo_count_o=4, 5th held until a pop.
REQ-034 SHALL cover: flush_i in cycle 3 with 3 buffered and 2 in flight -> cycle 4 fifo_count_o=0, no further fetch/commit valids, busy_o=0.
REQ-035 SHALL cover: rst_i asserted mid-drain with full FIFO -> outputs immediately at reset values; after release first new instr issues with no stall.
REQ-036 SHALL cover: continuous stream of 10 non-drain instrs -> one issue per cycle, inst_ready_o stays 1, pointers wrap, order preserved.

Source files
------------

// File: rtl/common_pkg.sv
// Shared scheduler types: instruction word, decoded fetch/commit controls and drain timing.
package common_pkg;

    localparam int T_D = 3;

    localparam logic [3:0] OP_DRAIN = 4'hF;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] operand;
    } instruction_t;

    typedef struct packed {
        logic        valid;
        logic        drain;
        logic [11:0] addr;
    } fetch_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [11:0] operand;
    } commit_t;

    typedef struct packed {
        fetch_t  fetch;
        commit_t commit;
    } ctrl_signals_t;

endpackage

// File: rtl/decoder.sv
// Combinational instruction decoder producing fetch and commit controls for one instruction.
module decoder
    import common_pkg::*;
(
    input  instruction_t inst_i,
    output fetch_t       fetch_o,
    output commit_t      commit_o
);

    // Decode opcode/operand into fetch and commit fields.
    always_comb begin
        fetch_o          = '0;
        commit_o         = '0;
        fetch_o.valid    = 1'b1;
        fetch_o.drain    = (inst_i.opcode == OP_DRAIN);
        fetch_o.addr     = inst_i.operand;
        commit_o.valid   = 1'b1;
        commit_o.opcode  = inst_i.opcode;
        commit_o.operand = inst_i.operand;
    end

endmodule

// File: rtl/inst_fifo.sv
// Instruction buffer: circular FIFO with synchronous flush and a registered occupancy count.
module inst_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i && !full_o && !flush_i;
    assign w_pop   = pop_i && !empty_o && !flush_i;

    // Storage array; contents are only observed through the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/control_sched.sv
// Buffers instructions, issues one per cycle through the decoder, stalls after drains,
// and delays the decoded fetch/commit controls through independent flop chains.
module control_sched
    import common_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = T_D,
    parameter int FETCH_LAT    = 1,
    parameter int COMMIT_LAT   = T_D + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  instruction_t                inst_i,
    input  logic                        inst_valid_i,
    output logic                        inst_ready_o,
    input  logic                        flush_i,
    output ctrl_signals_t               ctrl_signals,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        busy_o
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_DRAIN = 1'b1
    } sched_state_t;

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    instruction_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_issue;
    logic         w_pipe_busy;
    fetch_t       w_dec_fetch;
    commit_t      w_dec_commit;
    fetch_t       w_fetch_in;
    commit_t      w_commit_in;

    fetch_t  r_fetch_pipe  [FETCH_LAT];
    commit_t r_commit_pipe [COMMIT_LAT];

    inst_fifo #(
        .WIDTH ($bits(instruction_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inst_valid_i),
        .pop_i   (w_issue),
        .flush_i (flush_i),
        .data_i  (inst_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (fifo_count_o)
    );

    decoder u_decoder (
        .inst_i   (w_head),
        .fetch_o  (w_dec_fetch),
        .commit_o (w_dec_commit)
    );

    assign inst_ready_o = !w_full;
    assign w_issue      = !w_empty && (r_state == ST_ISSUE) && !flush_i;
    assign w_fetch_in   = w_issue ? w_dec_fetch : '0;
    assign w_commit_in  = w_issue ? w_dec_commit : '0;

    // Next state: counter holds remaining stall cycles; leave DRAIN after the cycle it reads 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_drain_cnt;
        if (flush_i) begin
            w_state_nxt = ST_ISSUE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    if (w_issue && w_dec_fetch.drain) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CNT_W'(DRAIN_CYCLES);
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    w_cnt_nxt = r_drain_cnt - CNT_W'(1);
                    if (r_drain_cnt <= CNT_W'(1)) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = ST_ISSUE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and drain counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_ISSUE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_cnt_nxt;
        end
    end

    // Fetch and commit delay chains; flush clears every stage, payload included.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FETCH_LAT; i++) r_fetch_pipe[i] <= '0;
            for (int i = 0; i < COMMIT_LAT; i++) r_commit_pipe[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < FETCH_LAT; i++) r_fetch_pipe[i] <= '0;
            for (int i = 0; i < COMMIT_LAT; i++) r_commit_pipe[i] <= '0;
        end else begin
            r_fetch_pipe[0]  <= w_fetch_in;
            r_commit_pipe[0] <= w_commit_in;
            for (int i = 1; i < FETCH_LAT; i++) r_fetch_pipe[i] <= r_fetch_pipe[i-1];
            for (int i = 1; i < COMMIT_LAT; i++) r_commit_pipe[i] <= r_commit_pipe[i-1];
        end
    end

    // Any valid stage in either chain keeps the block busy.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < FETCH_LAT; i++) w_pipe_busy = w_pipe_busy | r_fetch_pipe[i].valid;
        for (int i = 0; i < COMMIT_LAT; i++) w_pipe_busy = w_pipe_busy | r_commit_pipe[i].valid;
    end

    assign ctrl_signals.fetch  = r_fetch_pipe[FETCH_LAT-1];
    assign ctrl_signals.commit = r_commit_pipe[COMMIT_LAT-1];
    assign busy_o = (fifo_count_o != '0) || (r_state == ST_DRAIN) || w_pipe_busy;

endmodule
